register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
Parametrised successor to the fixed 16x16 two-read-port register file. Width, register count and read-port count are configurable, and it adds a per-register pending-write scoreboard and a sequenced bulk-clear engine. It sits between decode/control and the ALU/load path. Control uses `rd_ready` to stall on operands whose producer has not yet written back.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, number of registers; must be a power of two, >= 2.
- NUM_RD, 2, number of independent read ports.
- ADDR_W (localparam), $clog2(NUM_REGS), register address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data (ALU/load result).
- rd_addr  in  NUM_RD*ADDR_W  packed read indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing.
- rd_ready  out  NUM_RD  1 = addressed register is not pending and no clear is in progress.
- sb_set  in  1  mark sb_addr pending (long-latency producer issued).
- sb_addr  in  ADDR_W  scoreboard set index.
- clr_req  in  1  request a bulk clear of all registers.
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (reset=0, async):
  - All registers = 0; all busy bits = 0.
  - FSM = IDLE; clear counter = 0; clr_busy = 0; clr_done = 0.
- Write: on a rising edge with wr_en=1 and FSM=IDLE, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. The data is visible on reads the following cycle.
- Read: rd_data[i] = reg[rd_addr[i]], purely combinational, 0-cycle latency. All ports are independent, and any number may address the same register.
- Scoreboard:
  - sb_set=1 (IDLE only) sets busy[sb_addr] on the next edge.
  - sb_set and wr_en to the same address in the same cycle: set wins, busy=1 and the data is still written (a new producer is issued).
  - sb_set and wr_en to different addresses: both take effect.
  - rd_ready[i] = !busy[rd_addr[i]] && FSM==IDLE.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_req=1. At this edge all busy bits are cleared and the counter is set to 0.
  - CLEAR: reg[counter] <= 0 each cycle and counter increments. When counter == NUM_REGS-1, that register is zeroed and the FSM moves to DONE.
  - DONE: clr_done=1 for exactly one cycle, then IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - Total latency from clr_req sampled to clr_done = NUM_REGS+1 cycles.
  - Outside IDLE, wr_en, sb_set and clr_req are ignored; they are dropped, not queued.
  - Reads during CLEAR return the current partially-cleared contents, with rd_ready=0.
- Counter wrap: the counter is ADDR_W bits wide and never wraps inside CLEAR, because the exit is taken at NUM_REGS-1.
- Reset asserted mid-clear: everything returns to reset values immediately, and no clr_done pulse is produced.

Optional Feature:
REGFILE_BYPASS_EN.
- Defined: if wr_en=1, FSM=IDLE and rd_addr[i]==wr_addr, then rd_data[i]=wr_data and rd_ready[i]=1 in the same cycle (write-to-read forwarding).
- Undefined: rd_data[i] shows the old stored value until the edge, and rd_ready reflects the pre-write busy bit.

Decomposition:
- Package regfile_pkg holds:
  - the clear FSM state enum (IDLE/CLEAR/DONE, 2 bits);
  - default DATA_W/NUM_REGS constants;
  - the function clog2_safe.
- One sub-module, regfile_clear_seq: owns the FSM, the counter, clr_busy and clr_done, and outputs clr_we/clr_addr. Storage, scoreboard and read muxes stay in the top.

Test Plan:
1. Reset, then write 0xBEEF to r3 and read ports 0 and 1 both at r3 -> both return 0xBEEF the next cycle; all other registers read 0.
2. sb_set on r5, then read r5 -> rd_ready=0. Then wr_en r5=0x1234 -> rd_ready=1 and data 0x1234 the following cycle.
3. sb_set r7 and wr_en r7=0x00AA in the same cycle -> r7=0x00AA, busy[r7]=1.
4. Load all 16 registers with 0xFFFF, then pulse clr_req:
   - clr_busy=1 for 17 cycles and clr_done pulses once at cycle 17;
   - a write attempted mid-clear is dropped;
   - all registers read 0 afterwards.
5. Drop reset during CLEAR at count 6 -> immediately all registers 0, clr_busy=0, and no clr_done pulse.
6. With REGFILE_BYPASS_EN: wr_en r2=0x5A5A while reading r2 -> rd_data=0x5A5A in the same cycle. Without it -> the old value, and 0x5A5A the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register_file_sb block.
// Holds the clear-sequencer state encoding, the default geometry and a
// width helper that is safe to use for very small register counts.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 16;

  // Bulk-clear sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Address width for n entries. Never returns less than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer for register_file_sb.
// It walks the register index from 0 to NUM_REGS-1, zeroing one register per
// cycle, and then pulses clr_done for one cycle. clr_req is only accepted in
// IDLE. A request that arrives while a clear is in progress is dropped.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W   = clog2_safe(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] count;

  // The storage write port is driven directly from the state and counter flops.
  assign clr_we   = (state == CLEAR);
  assign clr_addr = count;

  // Clear FSM. The busy and done flags are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            count    <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // The exit is taken at the last index, so the counter never wraps.
          if (count == LAST_IDX) begin
            state    <= DONE;
            clr_done <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with a pending-write scoreboard and a bulk clear.
// - Reads are combinational on NUM_RD independent ports.
// - rd_ready drops while the addressed register has an outstanding producer,
//   and for the whole duration of a clear.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to matching
// read ports. When the macro is not defined, reads see the stored value until
// the write edge.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = clog2_safe(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                idle;
  logic                clr_we;
  logic [ADDR_W-1:0]   clr_addr;

  regfile_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // clr_busy is high exactly when the sequencer is outside IDLE.
  assign idle = !clr_busy;

  // Storage: the clear sequencer has priority, and normal writes are only accepted in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the array is reset explicitly because every register must read 0 after reset; this keeps it in flops rather than RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (idle && wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: a write retires its register, sb_set issues a new producer, and starting a clear wipes every bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (idle) begin
      if (clr_req) begin
        busy <= '0;
      end else begin
        if (wr_en) busy[wr_addr] <= 1'b0;
        // NOTE: with non-blocking assignments the later one wins, so set beats clear on the same address.
        if (sb_set) busy[sb_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] port_data;
    logic              port_ready;

    assign idx = rd_addr[g*ADDR_W +: ADDR_W];

    // Read mux for one port, with optional write-to-read forwarding.
    always_comb begin
      // NOTE: both outputs get a value on every path first, so no latch can be inferred.
      port_data  = regs[idx];
      port_ready = !busy[idx] && idle;
`ifdef REGFILE_BYPASS_EN
      if (idle && wr_en && (idx == wr_addr)) begin
        port_data  = wr_data;
        port_ready = 1'b1;
      end
`endif
    end

    assign rd_data[g*DATA_W +: DATA_W] = port_data;
    assign rd_ready[g]                 = port_ready;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb at its default geometry (16x16, 2 read ports).
// Read expectations come from a bench-side model and are queued on a scoreboard.
// They are popped and compared once the combinational outputs have settled.
// Control outputs are compared inline in each scenario task.
module tb_register_file_sb;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;

  logic            clk;
  logic            reset;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_ready;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            clr_req;
  logic            clr_busy;
  logic            clr_done;

  typedef struct {
    int            port;
    int            addr;
    logic [DW-1:0] data;
    logic          ready;
  } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model_regs [NR];
  logic          model_busy [NR];

  register_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // Inputs change only at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    wr_en   = 1'b0;
    sb_set  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic model_zero();
    for (int r = 0; r < NR; r++) begin
      model_regs[r] = '0;
      model_busy[r] = 1'b0;
    end
  endtask

  // Point a read port at addr and queue what it must show.
  task automatic expect_read(input int port, input int addr, input logic [DW-1:0] data,
                             input logic ready);
    exp_t e;
    rd_addr[port*AW +: AW] = addr[AW-1:0];
    e.port  = port;
    e.addr  = addr;
    e.data  = data;
    e.ready = ready;
    exp_q.push_back(e);
  endtask

  // Scoreboard drain: let the combinational reads settle, then pop and compare.
  task automatic sb_compare(input string tag);
    exp_t e;
    #1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_ready[e.port] !== e.ready) begin
        errors++;
        $display("FAIL %s port%0d r%0d: got data=%h ready=%b, expected data=%h ready=%b",
                 tag, e.port, e.addr, rd_data[e.port*DW +: DW], rd_ready[e.port],
                 e.data, e.ready);
      end
    end
  endtask

  task automatic write_reg(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
    model_regs[a] = d;
    model_busy[a] = 1'b0;
  endtask

  task automatic test_reset();
    model_zero();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b, expected 0 0", clr_busy, clr_done);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int r = 0; r < NR; r += 2) begin
      expect_read(0, r, 16'h0000, 1'b1);
      expect_read(1, r + 1, 16'h0000, 1'b1);
      sb_compare("reset_regs");
    end
  endtask

  task automatic test_write_read();
    write_reg(3, 16'hBEEF);
    expect_read(0, 3, 16'hBEEF, 1'b1);
    expect_read(1, 3, 16'hBEEF, 1'b1);
    sb_compare("wr_r3_both_ports");
    for (int r = 0; r < NR; r++) begin
      if (r != 3) begin
        expect_read(0, r, model_regs[r], 1'b1);
        sb_compare("others_zero");
      end
    end
  endtask

  task automatic test_scoreboard();
    sb_set  = 1'b1;
    sb_addr = 4'd5;
    tick();
    sb_set = 1'b0;
    model_busy[5] = 1'b1;
    expect_read(0, 5, 16'h0000, 1'b0);
    expect_read(1, 3, 16'hBEEF, 1'b1);
    sb_compare("sb_r5_pending");
    write_reg(5, 16'h1234);
    expect_read(0, 5, 16'h1234, 1'b1);
    sb_compare("sb_r5_retired");
  endtask

  task automatic test_set_write_same();
    // Same address: set wins, data still lands.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
    sb_set = 1'b1; sb_addr = 4'd7;
    tick();
    // Different addresses: both take effect.
    wr_addr = 4'd9; wr_data = 16'h0099;
    sb_addr = 4'd8;
    tick();
    drive_idle();
    model_regs[7] = 16'h00AA; model_busy[7] = 1'b1;
    model_regs[9] = 16'h0099; model_busy[8] = 1'b1;
    expect_read(0, 7, 16'h00AA, 1'b0);
    expect_read(1, 9, 16'h0099, 1'b1);
    sb_compare("set_write_same_diff");
    expect_read(0, 8, 16'h0000, 1'b0);
    sb_compare("sb_r8_other_addr");
  endtask

  task automatic test_clear();
    int nb = 0;
    int nd = 0;
    int done_at = 0;
    bit returned = 0;
    for (int r = 0; r < NR; r++) write_reg(r, 16'hFFFF);
    sb_set = 1'b1; sb_addr = 4'd4;
    tick();
    sb_set = 1'b0;
    expect_read(0, 4, 16'hFFFF, 1'b0);
    expect_read(1, 15, 16'hFFFF, 1'b1);
    sb_compare("pre_clear");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (clr_busy === 1'b1) nb++;
      if (clr_done === 1'b1) begin
        nd++;
        done_at = nb;
      end
      if (clr_busy !== 1'b1) begin
        returned = 1;
        break;
      end
      if (nb == 5) begin
        // Registers 0..3 are already zeroed in the fifth busy cycle.
        expect_read(0, 2, 16'h0000, 1'b0);
        expect_read(1, 10, 16'hFFFF, 1'b0);
        sb_compare("mid_clear_partial");
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1111;
        sb_set = 1'b1; sb_addr = 4'd2;
      end else if (nb == 8) begin
        drive_idle();
        clr_req = 1'b1;
      end else begin
        drive_idle();
      end
      tick();
    end
    drive_idle();
    checks++;
    if (!returned || nb != 17) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d busy cycles (returned=%0d), expected 17", nb, returned);
    end
    checks++;
    if (nd != 1 || done_at != 17) begin
      errors++;
      $display("FAIL clear_done_pulse: got %0d pulses at busy cycle %0d, expected 1 at 17", nd, done_at);
    end
    model_zero();
    for (int r = 0; r < NR; r += 2) begin
      expect_read(0, r, 16'h0000, 1'b1);
      expect_read(1, r + 1, 16'h0000, 1'b1);
      sb_compare("post_clear_zero");
    end
    tick();
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_dropped: got busy=%b, expected 0", clr_busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nd = 0;
    write_reg(12, 16'hC0DE);
    write_reg(13, 16'h0BAD);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (clr_done === 1'b1) nd++;
      tick();
    end
    // Counter is 6 in this cycle, so r12 is still intact.
    expect_read(0, 12, 16'hC0DE, 1'b0);
    sb_compare("pre_reset_mid_clear");
    checks++;
    if (clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_count6: got %b, expected 1", clr_busy);
    end
    reset = 1'b0;
    model_zero();
    #1;
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear_ctrl: got busy=%b done=%b, expected 0 0", clr_busy, clr_done);
    end
    expect_read(0, 12, 16'h0000, 1'b1);
    expect_read(1, 13, 16'h0000, 1'b1);
    sb_compare("reset_mid_clear_regs");
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (clr_done === 1'b1 || clr_busy === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d busy/done cycles, expected 0", nd);
    end
  endtask

  task automatic test_bypass();
    // Give r2 a known old value and an outstanding producer.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1111;
    sb_set = 1'b1; sb_addr = 4'd2;
    tick();
    sb_set = 1'b0;
    wr_data = 16'h5A5A;
`ifdef REGFILE_BYPASS_EN
    expect_read(0, 2, 16'h5A5A, 1'b1);
    expect_read(1, 2, 16'h5A5A, 1'b1);
`else
    expect_read(0, 2, 16'h1111, 1'b0);
    expect_read(1, 2, 16'h1111, 1'b0);
`endif
    sb_compare("bypass_same_cycle");
    tick();
    wr_en = 1'b0;
    expect_read(0, 2, 16'h5A5A, 1'b1);
    expect_read(1, 2, 16'h5A5A, 1'b1);
    sb_compare("bypass_next_cycle");
  endtask

  initial begin
    reset   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    sb_addr = '0;
    drive_idle();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_set_write_same();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
